btn_cond: RTL and testbench

Button conditioner sitting directly upstream of the ten-thirty game core. It takes the raw middle/right push-button inputs, synchronizes and debounces each one, and produces a clean level plus a press pulse per button. The pulse is held until the game's slow-rate tick consumes it, so no press is lost or double-counted across the clock-divider boundary.

---
 rtl/btn_cond_pkg.sv | 19 +
 rtl/btn_cond_ch.sv | 154 +++++++++++++++
 rtl/btn_cond.sv | 34 +++
 tb/tb_btn_cond.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and constants for the button conditioner.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        LOW,
        RISE_CHK,
        HIGH,
        FALL_CHK
    } btn_state_t;

    localparam int BTN_M = 0;
    localparam int BTN_R = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// One button channel: 2-FF synchronizer, debounce FSM, held press pulse.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses while pressed.
module btn_cond_ch
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic lvl,
    output logic p
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 2 || HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
        $error("btn_cond_ch: illegal parameter value");
    end

    logic             s1;
    logic             s2;
    btn_state_t       state;
    btn_state_t       state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             pend;
    logic             pend_nx;
    logic             acc;
    logic             set;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(max_int(HOLD_CYC, REPEAT_CYC) + 1);

    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic          rep;
    logic          rep_nx;
    logic          fire;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LOW;
            cnt   <= '0;
            pend  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hcnt  <= '0;
            rep   <= 1'b0;
`endif
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
`ifdef BTN_AUTOREPEAT_EN
            hcnt  <= hcnt_nx;
            rep   <= rep_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc      = 1'b0;
        unique case (state)
            LOW: begin
                if (s2) begin
                    state_nx = RISE_CHK;
                    cnt_nx   = '0;
                end
            end
            RISE_CHK: begin
                if (!s2) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else if (cnt == CNT_TOP) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                    acc      = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nx = FALL_CHK;
                    cnt_nx   = '0;
                end
            end
            FALL_CHK: begin
                if (s2) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CNT_TOP) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = LOW;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    // First repeat after HOLD_CYC, then every REPEAT_CYC; rep marks the phase.
    always_comb begin
        fire    = 1'b0;
        hcnt_nx = '0;
        rep_nx  = 1'b0;
        if (state == HIGH) begin
            fire = rep ? (hcnt == HW'(REPEAT_CYC - 1))
                       : (hcnt == HW'(HOLD_CYC - 1));
        end
        if (state == HIGH && state_nx == HIGH) begin
            hcnt_nx = fire ? '0 : hcnt + 1'b1;
            rep_nx  = rep | fire;
        end
    end

    assign set = acc | fire;
`else
    assign set = acc;
`endif

    // A new press wins over a same-cycle consume.
    always_comb begin
        pend_nx = pend;
        if (tick) begin
            pend_nx = 1'b0;
        end
        if (set) begin
            pend_nx = 1'b1;
        end
    end

    always_comb begin
        lvl = (state == HIGH) || (state == FALL_CHK);
        p   = pend;
    end

endmodule

// File: rtl/btn_cond.sv
// Button conditioner: N_BTN independent debounced channels sharing tick.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat press pulses.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int N_BTN        = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 20_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_lvl,
    output logic [N_BTN-1:0] btn_p
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_cond_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .HOLD_CYC    (HOLD_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .tick(tick),
            .raw (btn_raw[i]),
            .lvl (btn_lvl[i]),
            .p   (btn_p[i])
        );
    end

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond: directed tables plus random stimulus.
// Auto-repeat expectations switch on BTN_AUTOREPEAT_EN.
module tb_btn_cond;

    localparam int N = 2;
    localparam int D = 8;
    localparam int H = 16;
    localparam int R = 6;

    typedef struct {
        logic [1:0] raw;
        logic       tick;
        logic [1:0] lvl;
        logic [1:0] p;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] btn_raw;
    logic [1:0] btn_lvl;
    logic [1:0] btn_p;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl[32];

    always #5 clk = ~clk;

    btn_cond #(
        .N_BTN       (N),
        .DEBOUNCE_CYC(D),
        .HOLD_CYC    (H),
        .REPEAT_CYC  (R)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .btn_raw(btn_raw),
        .btn_lvl(btn_lvl),
        .btn_p  (btn_p)
    );

    // Reference: a level is accepted after D+1 consecutive synced samples
    // that disagree with it; synced sample = raw seen two edges earlier.
    logic [1:0] m_lvl;
    logic [1:0] m_p;
    logic [1:0] rq[$];
    int         run[2];
    int         age[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lvl = '0;
            m_p   = '0;
            rq.delete();
            for (int i = 0; i < N; i++) begin
                run[i] = 0;
                age[i] = 0;
            end
        end else begin
            logic [1:0] s;
            s = (rq.size() >= 2) ? rq[rq.size() - 2] : 2'b00;
            rq.push_back(btn_raw);
            if (rq.size() > 2) void'(rq.pop_front());
            for (int i = 0; i < N; i++) begin
                bit fire;
                bit rise;
                fire = 1'b0;
                rise = 1'b0;
                if (m_lvl[i] && run[i] == 0) begin
                    age[i]++;
`ifdef BTN_AUTOREPEAT_EN
                    fire = (age[i] >= H) && ((age[i] - H) % R == 0);
`endif
                end else begin
                    age[i] = 0;
                end
                if (s[i] != m_lvl[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == D + 1) begin
                    m_lvl[i] = s[i];
                    run[i]   = 0;
                    rise     = s[i];
                end
                if (rise || fire) m_p[i] = 1'b1;
                else if (tick) m_p[i] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] act,
                       input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] r, input logic t);
        btn_raw = r;
        tick    = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        for (int j = 0; j < 14; j++) cyc(2'b00, (j % 4) == 3);
    endtask

    initial begin
        int         rem[2];
        logic [1:0] rr;

        rst     = 1'b1;
        tick    = 1'b0;
        btn_raw = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("reset_lvl", btn_lvl, 2'b00);
        chk("reset_p", btn_p, 2'b00);
        rst = 1'b0;
        repeat (3) cyc(2'b00, 1'b0);

        // Clean press on bit 0, held 20 cycles, tick every 4th cycle.
        for (int j = 0; j < 32; j++) begin
            tbl[j].raw  = (j < 20) ? 2'b01 : 2'b00;
            tbl[j].tick = (j % 4) == 3;
            tbl[j].lvl  = (j >= 10 && j < 30) ? 2'b01 : 2'b00;
            tbl[j].p    = (j == 10) ? 2'b01 : 2'b00;
        end
        for (int j = 0; j < 32; j++) begin
            cyc(tbl[j].raw, tbl[j].tick);
            chk($sformatf("press_lvl[%0d]", j), btn_lvl, tbl[j].lvl);
            chk($sformatf("press_p[%0d]", j), btn_p, tbl[j].p);
        end

        // Glitch on bit 1: five cycles high, never accepted.
        for (int j = 0; j < 20; j++) begin
            cyc((j < 5) ? 2'b10 : 2'b00, (j % 4) == 3);
            chk($sformatf("glitch_lvl[%0d]", j), btn_lvl, 2'b00);
            chk($sformatf("glitch_p[%0d]", j), btn_p, 2'b00);
        end

        // Pulse held across a long tick-free wait.
        for (int j = 0; j <= 50; j++) begin
            cyc(2'b01, j == 50);
            chk($sformatf("hold_p[%0d]", j), btn_p,
                (j >= 10 && j < 50) ? 2'b01 : 2'b00);
        end
        settle();
        chk("hold_release_lvl", btn_lvl, 2'b00);

        // Both buttons pressed together, one tick clears both.
        for (int j = 0; j < 15; j++) begin
            cyc(2'b11, j == 12);
            chk($sformatf("both_lvl[%0d]", j), btn_lvl,
                (j >= 10) ? 2'b11 : 2'b00);
            chk($sformatf("both_p[%0d]", j), btn_p,
                (j == 10 || j == 11) ? 2'b11 : 2'b00);
        end
        settle();

        // Reset while bit 0 pending and bit 1 mid-debounce.
        for (int j = 0; j < 12; j++) cyc((j >= 5) ? 2'b11 : 2'b01, 1'b0);
        chk("prerst_p", btn_p, 2'b01);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_lvl", btn_lvl, 2'b00);
        chk("async_rst_p", btn_p, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j <= 10; j++) begin
            cyc(2'b11, 1'b0);
            chk($sformatf("rerelease_p[%0d]", j), btn_p,
                (j >= 10) ? 2'b11 : 2'b00);
        end
        settle();

        // Long hold with tick every cycle: repeats only when enabled.
        for (int j = 0; j < 60; j++) begin
            logic [1:0] ep;
`ifdef BTN_AUTOREPEAT_EN
            ep = (j == 10 || j == 26 || j == 32 || j == 38 || j == 44)
                 ? 2'b01 : 2'b00;
`else
            ep = (j == 10) ? 2'b01 : 2'b00;
`endif
            cyc((j < 46) ? 2'b01 : 2'b00, 1'b1);
            chk($sformatf("repeat_p[%0d]", j), btn_p, ep);
        end
        settle();

        // Random bouncing against the reference model.
        rr  = 2'b00;
        rem[0] = 0;
        rem[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    rr[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0)
                        rem[i] = int'($urandom_range(1, D));
                    else
                        rem[i] = int'($urandom_range(D, 40));
                end else begin
                    rem[i]--;
                end
            end
            cyc(rr, $urandom_range(0, 3) == 0);
            chk("rand_lvl", btn_lvl, m_lvl);
            chk("rand_p", btn_p, m_p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
